// File: rtl/ex_div_unit.sv
// ============================================================================
// ex_div_unit : 32-bit radix-2 restoring divider (DIV/DIVU), {rem, quo} result
// Optional macro: DIV_ZERO_FAST_EN (1-cycle divide-by-zero)   Revision: 1.0
// ============================================================================
`default_nettype none

module ex_div_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [5:0]  LAST_ITER = 6'd31;
  localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] raw_q, raw_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        zero_q, zero_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] mag1, mag2;
  logic [32:0] shift_rem;
  logic        no_borrow;
  logic [31:0] sub_rem;
  logic [31:0] quo_nxt, rem_nxt;
  logic [31:0] quo_fin, rem_fin;

  assign mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // quo_q doubles as the dividend shift register; its MSB feeds the remainder.
  // The remainder stays below the divisor, so 32 bits of the difference suffice.
  assign shift_rem = {rem_q, quo_q[31]};
  assign no_borrow = (shift_rem >= {1'b0, dvs_q});
  assign sub_rem   = shift_rem[31:0] - dvs_q;
  assign quo_nxt   = {quo_q[30:0], no_borrow};
  assign rem_nxt   = no_borrow ? sub_rem : shift_rem[31:0];
  assign quo_fin   = negq_q ? (~quo_nxt + 32'd1) : quo_nxt;
  assign rem_fin   = negr_q ? (~rem_nxt + 32'd1) : rem_nxt;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    raw_d    = raw_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    zero_d   = zero_q;
    result_d = result_q;
    ready_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          quo_d   = mag1;
          dvs_d   = mag2;
          rem_d   = 32'd0;
          raw_d   = opdata1_i;
          negq_d  = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
          negr_d  = signed_div_i && opdata1_i[31];
          zero_d  = (opdata2_i == 32'd0);
          cnt_d   = 6'd0;
          state_d = S_BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (opdata2_i == 32'd0) begin
            state_d  = S_DONE;
            result_d = {opdata1_i, ALL_ONES};
            ready_d  = 1'b1;
          end
`else
`endif
        end
      end

      S_BUSY: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          quo_d = quo_nxt;
          rem_d = rem_nxt;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) begin
            state_d = S_DONE;
            ready_d = 1'b1;
            // Zero divisor bypasses sign fix-up so both modes return the raw dividend.
            result_d = zero_q ? {raw_q, ALL_ONES} : {rem_fin, quo_fin};
          end
        end
      end

      S_DONE: begin
        if (annul_i || !start_i) begin
          state_d = S_IDLE;
        end else begin
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      dvs_q    <= 32'd0;
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      raw_q    <= 32'd0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      raw_q    <= raw_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_div_unit.sv
// Testbench for ex_div_unit: vector table plus scoreboard queue and
// hand sequences for hold, annul and mid-operation reset.
`default_nettype none

module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        annul;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] result;
  logic        ready;

  always #5 clk = ~clk;

  ex_div_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .annul_i      (annul),
    .signed_div_i (sgn),
    .opdata1_i    (a),
    .opdata2_i    (b),
    .result_o     (result),
    .ready_o      (ready)
  );

  typedef struct {
    logic        s;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] exp;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] sb_q[$];
  vec_t        vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q;
    logic [31:0] r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r, q};
  endfunction

  function automatic int exp_lat(input logic [31:0] y);
`ifdef DIV_ZERO_FAST_EN
    if (y == 32'd0) return 1;
`else
`endif
    return 33;
  endfunction

  // Drives a request, returns after ready (or timeout); start is left high.
  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp, input string name, output logic ok);
    int          k;
    logic [63:0] want;
    sb_q.push_back(exp);
    @(negedge clk);
    sgn   = s;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    a   = 32'hDEAD_BEEF;
    b   = 32'h0000_0003;
    sgn = ~s;
    k   = 0;
    while (!ready && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    want = sb_q.pop_front();
    if (!ready) begin
      check({name, " timeout"}, 64'(ready), 64'd1);
      ok = 1'b0;
    end else begin
      check(name, result, want);
      check({name, " latency"}, 64'(k + 1), 64'(exp_lat(y)));
      ok = 1'b1;
    end
  endtask

  task automatic run_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input string name);
    logic ok;
    issue(s, x, y, exp, name, ok);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    if (ok) check({name, " drop"}, 64'(ready), 64'd0);
  endtask

  initial begin
    logic        ok;
    logic        seen;
    logic [63:0] held;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,        64'hFFFFFFFF_FFFFFFFD};
    vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 64'h00000000_80000000};
    vecs[3]  = '{1'b0, 32'h0000_1234,  32'd0,        64'h00001234_FFFFFFFF};
    vecs[4]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 64'h00000001_FFFFFFFD};
    vecs[5]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 64'hFFFFFFFF_00000003};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'h00000000_00000001};
    vecs[7]  = '{1'b0, 32'd5,          32'd10,       64'h00000005_00000000};
    vecs[8]  = '{1'b1, 32'hFFFF_FFFF,  32'd0,        64'hFFFFFFFF_FFFFFFFF};
    vecs[9]  = '{1'b1, 32'h8000_0000,  32'd2,        64'h00000000_C0000000};
    vecs[10] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 64'h80000000_00000000};
    vecs[11] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        64'h00000000_FFFFFFFF};
    for (int i = 12; i < 18; i++) begin
      vecs[i].s   = 1'($urandom_range(0, 1));
      vecs[i].x   = $urandom;
      vecs[i].y   = $urandom >> $urandom_range(0, 28);
      if (vecs[i].y == 32'd0) vecs[i].y = 32'd13;
      vecs[i].exp = model(vecs[i].s, vecs[i].x, vecs[i].y);
    end

    rst   = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    sgn   = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 64'(ready), 64'd0);
    check("reset result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Hold start after ready: result must stay put, then drop.
    issue(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "hold", ok);
    held = 64'h00000002_0000000E;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold ready %0d", i), 64'(ready), 64'd1);
      check($sformatf("hold result %0d", i), result, held);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("hold release ready", 64'(ready), 64'd0);
    check("hold release result", result, held);

    // Annul at BUSY iteration 10.
    @(negedge clk);
    sgn   = 1'b0;
    a     = 32'd85;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    annul = 1'b0;
    check("annul ready", 64'(ready), 64'd0);
    check("annul result", result, held);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready) seen = 1'b1;
    end
    check("annul no ready", 64'(seen), 64'd0);
    run_op(1'b0, 32'd85, 32'd3, 64'h00000001_0000001C, "after annul");

    // Reset at BUSY iteration 20.
    @(negedge clk);
    sgn   = 1'b1;
    a     = 32'hFFFF_FF00;
    b     = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("busy reset ready", 64'(ready), 64'd0);
    check("busy reset result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b1, 32'hFFFF_FF00, 32'd5, model(1'b1, 32'hFFFF_FF00, 32'd5), "after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
